vga_timing_gen: RTL

//   Raster timing source for the VGA pipeline: free-running horizontal and vertical

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Purpose: free-running VGA raster timing with hpos/vpos, syncs, blanking and frame markers.
// Latency: 1 cycle from counter state to every output; all outputs are registered together.
// Backpressure: none; the block has no inputs besides clk/rst_n and never stalls.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_count
);

    // Totals must fit in 10 bits; every constant is sized to the counter width.
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS_END = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Internal counters park at the last pixel in reset so the first edge lands on (0,0).
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       primed;

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       frame_wrap;
    logic       vis_nxt;
    logic       hs_act_nxt;
    logic       vs_act_nxt;

    // Next-state counters and decode; outputs register this so they share one pixel.
    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        frame_wrap = h_wrap && (v_cnt == V_LAST);
        h_nxt      = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt      = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
        vis_nxt    = (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
        hs_act_nxt = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
        // v_nxt only moves on a horizontal wrap, so vsync is line-aligned by construction.
        vs_act_nxt = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    end

    // Counter state and the primed flag that keeps the first (0,0) out of frame_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt  <= H_LAST;
            v_cnt  <= V_LAST;
            primed <= 1'b0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (frame_wrap) begin
                primed <= 1'b1;
            end
        end
    end

    // Registered outputs, all decoded from the same next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= 10'd0;
            vpos        <= 10'd0;
            visible     <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 10'd0;
        end else begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            visible     <= vis_nxt;
            hsync       <= hs_act_nxt ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act_nxt ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= h_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap && primed) begin
                frame_count <= frame_count + 10'd1;
            end
        end
    end

endmodule
